// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// One request in flight; a miss may spill a dirty victim (WRITEBACK) before
// the line is filled (ALLOCATE) and the lookup is replayed in COMPARE.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is
// defined; otherwise hit_count/miss_count are tied to zero.
module dcache_ctrl #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_input_valid,
  input  logic [31:0]              addr,
  input  logic [31:0]              din,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic [31:0]              dout,
  output logic                     is_ready,
  output logic                     is_output_valid,
  output logic                     is_hit,
  output logic                     mem_req,
  output logic                     mem_req_write,
  output logic [31:0]              mem_req_addr,
  output logic [LINE_WORDS*32-1:0] mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [LINE_WORDS*32-1:0] mem_resp_rdata,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int LINE_BITS = LINE_WORDS * 32;
  localparam int IDX_W     = $clog2(NUM_SETS);
  localparam int TAG_W     = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, nxt;

  // Captured request; word address only, byte offset is dropped at capture.
  logic [29:0] req_word;
  logic [31:0] req_din;
  logic        req_wr;
  logic        req_missed;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_off;
  assign req_off = req_word[1:0];
  assign req_idx = req_word[IDX_W+1:2];
  assign req_tag = req_word[29:IDX_W+2];

  // Line state and storage
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
  logic [LINE_BITS-1:0] data_mem [NUM_SETS];

  logic [TAG_W-1:0]     tag_rd;
  logic [LINE_BITS-1:0] line_rd;
  logic [31:0]          word_rd;
  logic                 hit;
  logic                 accept;

  assign tag_rd  = tag_mem[req_idx];
  assign line_rd = data_mem[req_idx];
  assign word_rd = line_rd[{req_off, 5'b0} +: 32];
  assign hit     = valid_q[req_idx] && (tag_rd == req_tag);
  assign accept  = (state == IDLE) && is_input_valid && (mem_read || mem_write);

  // State register; reset aborts whatever is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (accept) nxt = COMPARE;
      COMPARE: begin
        if (hit)                                    nxt = IDLE;
        else if (valid_q[req_idx] && dirty_q[req_idx]) nxt = WRITEBACK;
        else                                        nxt = ALLOCATE;
      end
      WRITEBACK: if (mem_resp_valid) nxt = ALLOCATE;
      ALLOCATE:  if (mem_resp_valid) nxt = COMPARE;
      default:   nxt = IDLE;
    endcase
  end

  // Outputs decoded from the current state; memory port is zero unless busy.
  always_comb begin
    is_ready        = (state == IDLE) && !reset;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = '0;
    mem_req         = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    case (state)
      COMPARE: begin
        if (hit) begin
          is_output_valid = 1'b1;
          is_hit          = !req_missed;
          if (!req_wr) dout = word_rd;
        end
      end
      WRITEBACK: begin
        mem_req       = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_rd, req_idx, 4'b0};
        mem_req_wdata = line_rd;
      end
      ALLOCATE: begin
        mem_req       = 1'b1;
        mem_req_addr  = {req_tag, req_idx, 4'b0};
      end
      default: ;
    endcase
  end

  // Request capture; a read+write strobe is a store. Replays remember the miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_word   <= '0;
      req_din    <= '0;
      req_wr     <= 1'b0;
      req_missed <= 1'b0;
    end else if (accept) begin
      req_word   <= addr[31:2];
      req_din    <= din;
      req_wr     <= mem_write;
      req_missed <= 1'b0;
    end else if (state == COMPARE && !hit) begin
      req_missed <= 1'b1;
    end
  end

  // Valid/dirty bits; cleared on reset so stale dirty data is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (state)
        COMPARE:   if (hit && req_wr) dirty_q[req_idx] <= 1'b1;
        WRITEBACK: if (mem_resp_valid) dirty_q[req_idx] <= 1'b0;
        ALLOCATE: begin
          if (mem_resp_valid) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: no reset, writes suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ALLOCATE && mem_resp_valid) begin
        data_mem[req_idx] <= mem_resp_rdata;
        tag_mem[req_idx]  <= req_tag;
      end else if (state == COMPARE && hit && req_wr) begin
        data_mem[req_idx][{req_off, 5'b0} +: 32] <= req_din;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // First-lookup hit/miss counters, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state == COMPARE && !req_missed) begin
      if (hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven vectors with a result scoreboard, a backing
// memory responder that logs every line request, and hand-written sequences
// for ignored strobes, stray memory responses and reset mid-fill.
module tb_dcache_ctrl;

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         is_input_valid = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  din = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  dout;
  logic         is_ready, is_output_valid, is_hit;
  logic         mem_req, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  wire          mem_resp_valid;
  wire  [127:0] mem_resp_rdata;
  logic [31:0]  hit_count, miss_count;

  logic         resp_drv = 1'b0, inj = 1'b0;
  logic [127:0] resp_data = '0, inj_data = '0;
  assign mem_resp_valid = resp_drv | inj;
  assign mem_resp_rdata = inj ? inj_data : resp_data;

  dcache_ctrl #(.NUM_SETS(16), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .din(din), .mem_read(mem_read), .mem_write(mem_write), .dout(dout),
    .is_ready(is_ready), .is_output_valid(is_output_valid), .is_hit(is_hit),
    .mem_req(mem_req), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory: preloaded line 0x40, other lines default to 0xA5000000|addr.
  logic [127:0] bmem [int unsigned];

  function automatic logic [127:0] get_line(input logic [31:0] a);
    logic [127:0] l;
    if (bmem.exists(a)) return bmem[a];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hA500_0000 | (a + 32'(k*4));
    return l;
  endfunction

  typedef struct { logic w; logic [31:0] a; logic [127:0] d; } mreq_t;
  mreq_t mlog[$];

  // Responder: logs each request, answers 3 cycles later unless it was aborted.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !reset) begin
        mreq_t t;
        t.w = mem_req_write; t.a = mem_req_addr; t.d = mem_req_wdata;
        mlog.push_back(t);
        if (t.w) bmem[t.a] = t.d;
        repeat (2) @(negedge clk);
        if (mem_req && !reset) begin
          resp_data = t.w ? 128'h0 : get_line(t.a);
          resp_drv  = 1'b1;
          @(negedge clk);
          resp_drv  = 1'b0;
        end
      end
    end
  end

  // Scoreboard of expected completions
  typedef struct { logic [31:0] dout; logic hit; } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (is_output_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got dout %0h with nothing expected", dout);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("dout", 128'(dout), 128'(e.dout));
          chk("is_hit", 128'(is_hit), 128'(e.hit));
        end
      end else begin
        chk("dout_idle_zero", 128'(dout), 128'h0);
      end
      if (!mem_req) begin
        chk("mreq_addr_idle", 128'({mem_req_write, mem_req_addr}), 128'h0);
        chk("mreq_wdata_idle", mem_req_wdata, 128'h0);
      end
    end
  end

  typedef struct {
    logic [31:0] addr; logic rd; logic wr; logic [31:0] din;
    logic [31:0] exp_dout; logic exp_hit;
    int nreq; logic [31:0] a0; logic [31:0] a1; logic [31:0] wd2;
  } vec_t;

  vec_t vecs[19];
  int hit_exp = 0, miss_exp = 0;

  // nreq==1: read of a0; nreq==2: writeback of a0 (word2 == wd2) then read of a1.
  function automatic vec_t mk(input logic [31:0] a, input logic rd, input logic wr,
                              input logic [31:0] d, input logic [31:0] ed, input logic eh,
                              input int n, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] wd2);
    vec_t v;
    v.addr = a; v.rd = rd; v.wr = wr; v.din = d; v.exp_dout = ed; v.exp_hit = eh;
    v.nreq = n; v.a0 = a0; v.a1 = a1; v.wd2 = wd2;
    return v;
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    exp_t e;
    int lat;
    v = vecs[i];
    mlog.delete();
    @(negedge clk);
    chk($sformatf("ready_v%0d", i), 128'(is_ready), 128'h1);
    is_input_valid = 1'b1; addr = v.addr; din = v.din; mem_read = v.rd; mem_write = v.wr;
    e.dout = v.exp_dout; e.hit = v.exp_hit;
    sbq.push_back(e);
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    lat = 1;
    while (!is_output_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!is_output_valid) begin
      checks++; errors++;
      $display("FAIL timeout_v%0d: got no completion expected one within 64 cycles", i);
      sbq.delete();
    end
    if (v.exp_hit) chk($sformatf("hit_latency_v%0d", i), 128'(lat), 128'd1);
    chk($sformatf("nreq_v%0d", i), 128'(mlog.size()), 128'(v.nreq));
    if (mlog.size() == v.nreq && v.nreq == 1) begin
      chk($sformatf("req0_v%0d", i), 128'({mlog[0].w, mlog[0].a}), 128'({1'b0, v.a0}));
    end else if (mlog.size() == v.nreq && v.nreq == 2) begin
      chk($sformatf("wb_v%0d", i), 128'({mlog[0].w, mlog[0].a}), 128'({1'b1, v.a0}));
      chk($sformatf("wb_word2_v%0d", i), 128'(mlog[0].d[95:64]), 128'(v.wd2));
      chk($sformatf("fill_v%0d", i), 128'({mlog[1].w, mlog[1].a}), 128'({1'b0, v.a1}));
    end
    @(negedge clk);
    if (v.exp_hit) hit_exp++; else miss_exp++;
    chk($sformatf("hit_count_v%0d", i), 128'(hit_count), STATS ? 128'(hit_exp) : 128'h0);
    chk($sformatf("miss_count_v%0d", i), 128'(miss_count), STATS ? 128'(miss_exp) : 128'h0);
  endtask

  initial begin
    int n;
    bmem[32'h40] = {32'd4, 32'd3, 32'd2, 32'd1};
    //            addr          rd wr din            dout           hit n  a0          a1          wd2
    vecs[0]  = mk(32'h40,       1, 0, 32'h0,         32'd1,         0, 1, 32'h40,     32'h0,      32'h0);
    vecs[1]  = mk(32'h44,       1, 0, 32'h0,         32'd2,         1, 0, 32'h0,      32'h0,      32'h0);
    vecs[2]  = mk(32'h48,       0, 1, 32'hDEADBEEF,  32'h0,         1, 0, 32'h0,      32'h0,      32'h0);
    vecs[3]  = mk(32'h440,      1, 0, 32'h0,         32'hA5000440,  0, 2, 32'h40,     32'h440,    32'hDEADBEEF);
    vecs[4]  = mk(32'h48,       1, 0, 32'h0,         32'hDEADBEEF,  0, 1, 32'h40,     32'h0,      32'h0);
    vecs[5]  = mk(32'h44,       1, 1, 32'h5,         32'h0,         1, 0, 32'h0,      32'h0,      32'h0);
    vecs[6]  = mk(32'h44,       1, 0, 32'h0,         32'h5,         1, 0, 32'h0,      32'h0,      32'h0);
    vecs[7]  = mk(32'h80,       1, 0, 32'h0,         32'hA5000080,  0, 1, 32'h80,     32'h0,      32'h0);
    vecs[8]  = mk(32'h8C,       0, 1, 32'h1234,      32'h0,         1, 0, 32'h0,      32'h0,      32'h0);
    vecs[9]  = mk(32'h8C,       1, 0, 32'h0,         32'h1234,      1, 0, 32'h0,      32'h0,      32'h0);
    vecs[10] = mk(32'h100,      0, 1, 32'hCAFE,      32'h0,         0, 1, 32'h100,    32'h0,      32'h0);
    vecs[11] = mk(32'h100,      1, 0, 32'h0,         32'hCAFE,      1, 0, 32'h0,      32'h0,      32'h0);
    vecs[12] = mk(32'h107,      1, 0, 32'h0,         32'hA5000104,  1, 0, 32'h0,      32'h0,      32'h0);
    vecs[13] = mk(32'hFC,       1, 0, 32'h0,         32'hA50000FC,  0, 1, 32'hF0,     32'h0,      32'h0);
    vecs[14] = mk(32'h1F8,      1, 0, 32'h0,         32'hA50001F8,  0, 1, 32'h1F0,    32'h0,      32'h0);
    vecs[15] = mk(32'h880,      0, 1, 32'h77,        32'h0,         0, 2, 32'h80,     32'h880,    32'hA5000088);
    vecs[16] = mk(32'h880,      1, 0, 32'h0,         32'h77,        1, 0, 32'h0,      32'h0,      32'h0);
    vecs[17] = mk(32'h44,       1, 0, 32'h0,         32'h5,         1, 0, 32'h0,      32'h0,      32'h0);
    vecs[18] = mk(32'h20,       1, 0, 32'h0,         32'hA5000020,  0, 1, 32'h20,     32'h0,      32'h0);

    // Reset state
    #12;
    chk("rst_ready", 128'(is_ready), 128'h0);
    chk("rst_outputs", 128'({is_output_valid, is_hit, mem_req, mem_req_write, dout}), 128'h0);
    chk("rst_counts", 128'({hit_count, miss_count}), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 128'(is_ready), 128'h1);

    for (int i = 0; i <= 16; i++) run_vec(i);

    // Strobe with no operation is ignored
    mlog.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      is_input_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h44;
      if (c > 0) chk($sformatf("noop_ready_%0d", c), 128'({is_ready, mem_req}), 128'h2);
    end
    @(negedge clk);
    chk("noop_ready_end", 128'({is_ready, mem_req}), 128'h2);
    is_input_valid = 1'b0;
    chk("noop_no_mreq", 128'(mlog.size()), 128'h0);

    // Stray memory response while idle changes nothing
    @(negedge clk);
    inj = 1'b1; inj_data = {128{1'b1}};
    @(negedge clk);
    inj = 1'b0;
    run_vec(17);

    // Reset in the middle of a fill
    mlog.delete();
    @(negedge clk);
    is_input_valid = 1'b1; addr = 32'h20; mem_read = 1'b1; mem_write = 1'b0;
    begin
      exp_t e;
      e.dout = 32'h0; e.hit = 1'b0;
      sbq.push_back(e);
    end
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("alloc_seen", 128'({mem_req, mem_req_write, mem_req_addr}), 128'({2'b10, 32'h20}));
    reset = 1'b1;
    #1;
    chk("abort_outputs", 128'({mem_req, is_output_valid, is_ready}), 128'h0);
    sbq.delete();
    repeat (3) @(negedge clk);
    chk("abort_counts", 128'({hit_count, miss_count}), 128'h0);
    reset = 1'b0;
    hit_exp = 0; miss_exp = 0;
    run_vec(18);

    repeat (4) @(negedge clk);
    chk("sb_drained", 128'(sbq.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected one before 200000");
    $fatal(1, "watchdog");
  end

endmodule
